sram_bank_array: RTL
====================

Name: sram_bank_array

Overview:
Parametrised banked, byte-laned synchronous single-port SRAM array behind a valid/ready request port. It generalises the fixed 2-bank x 4-lane x 8 KB SRAM top to N banks, L lanes and any power-of-two depth. It adds three behaviours: power-on zero initialisation, configurable read pipeline latency, and byte-strobe writes. It sits between the AHB SRAM controller/arbiter and the SRAM macros.

Parameters:
NUM_BANKS, 2, number of banks; power of two, >=1.
LANES, 4, byte lanes per word; one 8-bit macro per lane per bank.
DEPTH, 8192, rows per macro; power of two, >=2.
READ_LATENCY, 1, cycles from read acceptance to rdata_valid; legal values 1 or 2.
INIT_ON_RESET, 1, 1 = zero all rows after reset; 0 = skip initialisation.
Derived: ADDR_W = clog2(NUM_BANKS) + clog2(DEPTH). Illegal parameter values cause an elaboration error.

Ports:
sram_clk  in  1  sole clock; all state updates on its rising edge.
hresetn  in  1  synchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  array can accept a request this cycle.
req_write  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  word address; upper clog2(NUM_BANKS) bits = bank, lower bits = row.
req_wdata  in  LANES*8  write data; lane i = bits [8i+7:8i].
req_strb  in  LANES  per-lane write enable.
rdata  out  LANES*8  read data.
rdata_valid  out  1  rdata valid this cycle.
init_done  out  1  initialisation complete.
parity_err  out  1  present only with SRAM_PARITY_EN.

Behaviour:
- Reset (hresetn=0 at a clock edge): req_ready=0, rdata=0, rdata_valid=0, init_done=0, parity_err=0. Read pipeline flushed; FSM goes to INIT (INIT_ON_RESET=1) or RUN (INIT_ON_RESET=0). Memory contents are not cleared by reset itself.
- FSM states: INIT and RUN.
- INIT: row counter runs 0..DEPTH-1, one row per cycle. Each cycle writes zero to that row in every bank and lane, including stored parity (0 is correct for zero data). Takes DEPTH cycles after reset release. After the write to row DEPTH-1, the FSM enters RUN and init_done/req_ready are 1 in the next cycle. req_ready=0 throughout INIT; requests are ignored, not queued.
- RUN: req_ready=1 every cycle and init_done=1. A request is accepted when req_valid && req_ready.
- Bank select: only the addressed bank's macros get chip-enable; all other banks are idle.
- Write: lane i of the addressed row is updated iff req_strb[i]=1; other lanes keep their value. strb=0 is accepted with no change. No response is produced for writes.
- Read: rdata_valid pulses exactly READ_LATENCY cycles after the accepting edge, with the stored word on rdata.
  - Reads are pipelined: one per cycle, responses in order.
  - rdata holds its last value while rdata_valid=0.
- Read after write: a read accepted the cycle after a write to the same address returns the new data. Writes accepted between a read's acceptance and its rdata_valid do not alter that read's data.
- Reset mid-operation (any state, pending reads): in-flight reads are discarded. rdata_valid=0 from the cycle after reset is sampled. INIT restarts from row 0.
- No backpressure on rdata; the consumer must always accept.

Optional Feature:
SRAM_PARITY_EN.
- Defined:
  - Each lane stores 9 bits: data plus even parity, written on every lane write.
  - On read, parity is checked per lane. parity_err=1 in the same cycle as rdata_valid if any lane mismatches, otherwise 0.
  - parity_err is a pulse, not sticky, and is reset to 0.
- Undefined: 8-bit lane storage, no parity logic, parity_err port absent.

Test Plan:
- Init: DEPTH=2048, INIT_ON_RESET=1; release hresetn -> req_ready=0 for exactly 2048 cycles, then init_done=req_ready=1; read addr 0x000, 0x7FF, 0xFFF -> 0x00000000 each.
- Strobes: write 0xDEADBEEF strb 4'b1111 to 0x005, then 0x11223344 strb 4'b0101 to 0x005, then read 0x005 -> rdata=0xDE22BE44, rdata_valid exactly READ_LATENCY cycles after acceptance.
- Bank boundary: write 0xAAAA0001 to DEPTH-1 and 0xBBBB0002 to DEPTH; back-to-back reads -> 0xAAAA0001 then 0xBBBB0002 on consecutive cycles; only one bank enabled per access.
- Latency 2: READ_LATENCY=2; 16 consecutive reads of pre-written pattern addr*0x01010101 -> 16 consecutive rdata_valid pulses starting 2 cycles after the first acceptance, in order; a write to a pending address does not corrupt the pending read.
- Reset mid-burst: assert hresetn=0 for 1 cycle with 2 reads in flight -> no rdata_valid afterwards; init_done=0; INIT restarts (DEPTH cycles); previously written data reads back 0.
- Parity (SRAM_PARITY_EN): write 0x12345678; flip bit 9 of the stored word by hierarchical deposit; read -> rdata=0x12345478 with parity_err=1 in the same cycle; next clean read -> parity_err=0.

Source files
------------

// File: rtl/sram_bank_array.sv
// Banked, byte-laned single-port SRAM array: zero-init after reset, 1 or 2 cycle read pipeline.
// Define SRAM_PARITY_EN to store and check one even-parity bit per lane (adds parity_err).
module sram_bank_array #(
  parameter int unsigned NUM_BANKS     = 2,
  parameter int unsigned LANES         = 4,
  parameter int unsigned DEPTH         = 8192,
  parameter int unsigned READ_LATENCY  = 1,
  parameter int unsigned INIT_ON_RESET = 1,
  localparam int unsigned BankW  = $clog2(NUM_BANKS),
  localparam int unsigned RowW   = $clog2(DEPTH),
  localparam int unsigned ADDR_W = BankW + RowW
) (
  input  logic                  sram_clk,
  input  logic                  hresetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [LANES*8-1:0]    req_wdata,
  input  logic [LANES-1:0]      req_strb,
  output logic [LANES*8-1:0]    rdata,
  output logic                  rdata_valid,
  output logic                  init_done
`ifdef SRAM_PARITY_EN
  ,
  output logic                  parity_err
`endif
);

  if (NUM_BANKS == 0 || (NUM_BANKS & (NUM_BANKS - 1)) != 0) begin : g_bad_banks
    $error("NUM_BANKS must be a power of two >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (LANES == 0) begin : g_bad_lanes
    $error("LANES must be >= 1");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end
  if (INIT_ON_RESET > 1) begin : g_bad_init
    $error("INIT_ON_RESET must be 0 or 1");
  end

`ifdef SRAM_PARITY_EN
  localparam int unsigned LaneW = 9;
`else
  localparam int unsigned LaneW = 8;
`endif
  localparam int unsigned BankIdxW = (BankW > 0) ? BankW : 1;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [RowW-1:0]     init_row_q, init_row_d;
  logic                ready_q, init_done_q;
  logic [BankIdxW-1:0] bank_idx;
  logic [RowW-1:0]     row_idx;
  logic [NUM_BANKS-1:0] bank_ce;
  logic                acc_rd, acc_wr, init_wr;

  logic [LaneW-1:0]    mem_q [NUM_BANKS][DEPTH][LANES];
  logic [LaneW-1:0]    wr_lane [LANES];
  logic [LaneW-1:0]    rd_lane [LANES];
  logic [LANES*8-1:0]  rd_word;

  logic                s1_valid_q, rvalid_q, st_valid;
  logic [LANES*8-1:0]  s1_data_q, rdata_q, st_data;
`ifdef SRAM_PARITY_EN
  logic                rd_perr, s1_perr_q, st_perr, perr_q;
`endif

  // Request decode; requests arriving while in reset or INIT are dropped.
  always_comb begin
    row_idx  = req_addr[RowW-1:0];
    bank_idx = '0;
    if (NUM_BANKS > 1) bank_idx = BankIdxW'(req_addr >> RowW);
    acc_rd  = hresetn && req_valid && ready_q && !req_write;
    acc_wr  = hresetn && req_valid && ready_q && req_write;
    init_wr = hresetn && (state_q == StInit);
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_ce[b] = (acc_rd || acc_wr) && (bank_idx == BankIdxW'(b));
    end
  end

  always_comb begin
    rd_word = '0;
`ifdef SRAM_PARITY_EN
    rd_perr = 1'b0;
`endif
    for (int l = 0; l < LANES; l++) begin
`ifdef SRAM_PARITY_EN
      wr_lane[l] = {^req_wdata[8*l +: 8], req_wdata[8*l +: 8]};
`else
      wr_lane[l] = req_wdata[8*l +: 8];
`endif
      rd_lane[l]         = mem_q[bank_idx][row_idx][l];
      rd_word[8*l +: 8]  = rd_lane[l][7:0];
`ifdef SRAM_PARITY_EN
      rd_perr            = rd_perr | (^rd_lane[l]);
`endif
    end
  end

  // Storage is deliberately not reset; only the INIT sweep clears it.
  always_ff @(posedge sram_clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        if (init_wr) begin
          mem_q[b][init_row_q][l] <= '0;
        end else if (bank_ce[b] && req_write && req_strb[l]) begin
          mem_q[b][row_idx][l] <= wr_lane[l];
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    init_row_d = init_row_q;
    unique case (state_q)
      StInit: begin
        init_row_d = init_row_q + RowW'(1);
        if (init_row_q == RowW'(DEPTH - 1)) state_d = StRun;
      end
      StRun: ;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    if (READ_LATENCY == 1) begin
      st_valid = acc_rd;
      st_data  = rd_word;
`ifdef SRAM_PARITY_EN
      st_perr  = rd_perr;
`endif
    end else begin
      st_valid = s1_valid_q;
      st_data  = s1_data_q;
`ifdef SRAM_PARITY_EN
      st_perr  = s1_perr_q;
`endif
    end
  end

  always_ff @(posedge sram_clk) begin
    if (!hresetn) begin
      state_q     <= (INIT_ON_RESET != 0) ? StInit : StRun;
      init_row_q  <= '0;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
`ifdef SRAM_PARITY_EN
      s1_perr_q   <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      init_row_q  <= init_row_d;
      ready_q     <= (state_d == StRun);
      init_done_q <= (state_d == StRun);
      s1_valid_q  <= acc_rd;
      if (acc_rd) s1_data_q <= rd_word;
      rvalid_q    <= st_valid;
      if (st_valid) rdata_q <= st_data;
`ifdef SRAM_PARITY_EN
      if (acc_rd) s1_perr_q <= rd_perr;
      perr_q      <= st_valid && st_perr;
`endif
    end
  end

  assign req_ready   = ready_q;
  assign init_done   = init_done_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rvalid_q;
`ifdef SRAM_PARITY_EN
  assign parity_err  = perr_q;
`endif

endmodule
